// File: rtl/store_unit.sv
// Store unit: aligns and lane-formats SB/SH/SW requests, queues them in an in-order
// store buffer and drains them to the data-memory write port over req/gnt.
package store_unit_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    MEM_BYTE   = 3'd0,
    MEM_HALF   = 3'd1,
    MEM_WORD   = 3'd2,
    MEM_BYTE_U = 3'd4,
    MEM_HALF_U = 3'd5
  } mem_op_e;
endpackage

module store_unit
  import store_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            st_valid,
  output logic            st_ready,
  input  logic [XLEN-1:0] st_addr,
  input  logic [XLEN-1:0] st_wdata,
  input  mem_op_e         st_op,
  output logic            st_misaligned,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic [XLEN-1:0] ld_check_addr,
  output logic            ld_hazard,
  output logic            buf_empty,
  output logic [CNT_W-1:0] buf_count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0]  r_addr  [DEPTH];
  logic [XLEN-1:0]  r_wdata [DEPTH];
  logic [3:0]       r_be    [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic            w_misaligned;
  logic [XLEN-1:0] w_fmt_wdata;
  logic [3:0]      w_fmt_be;
  logic [XLEN-1:0] w_fmt_addr;
  logic            w_enq;
  logic            w_deq;
  logic            w_hit;

  // Alignment check and lane replication; unknown encodings behave as word stores
  always_comb begin
    w_misaligned = 1'b0;
    w_fmt_wdata  = st_wdata;
    w_fmt_be     = 4'b1111;
    case (st_op)
      MEM_BYTE, MEM_BYTE_U: begin
        w_misaligned = 1'b0;
        w_fmt_wdata  = {4{st_wdata[7:0]}};
        w_fmt_be     = 4'b0001 << st_addr[1:0];
      end
      MEM_HALF, MEM_HALF_U: begin
        w_misaligned = st_addr[0];
        w_fmt_wdata  = {2{st_wdata[15:0]}};
        w_fmt_be     = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_misaligned = |st_addr[1:0];
        w_fmt_wdata  = st_wdata;
        w_fmt_be     = 4'b1111;
      end
    endcase
  end

  assign w_fmt_addr    = {st_addr[XLEN-1:2], 2'b00};
  assign st_ready      = (r_count != CNT_W'(DEPTH));
  assign st_misaligned = st_valid & w_misaligned;
  assign w_enq         = st_valid & st_ready & ~w_misaligned;
  assign buf_empty     = (r_count == CNT_W'(0));
  assign buf_count     = r_count;
  assign mem_req       = ~buf_empty;
  assign w_deq         = mem_req & mem_gnt;
  assign mem_addr      = r_addr[r_rd_ptr];
  assign mem_wdata     = r_wdata[r_rd_ptr];
  assign mem_be        = r_be[r_rd_ptr];

  // Word-address match against every valid entry, including a head granted this cycle
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i][XLEN-1:2] == ld_check_addr[XLEN-1:2])) begin
        w_hit = 1'b1;
      end else begin
        w_hit = w_hit;
      end
    end
  end

  assign ld_hazard = w_hit;

  // Entry payload, written only at enqueue
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_wr_ptr]  <= w_fmt_addr;
      r_wdata[r_wr_ptr] <= w_fmt_wdata;
      r_be[r_wr_ptr]    <= w_fmt_be;
    end
  end

  // Pointers, valid bits and occupancy; reset wins over a coincident grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= PTR_W'(0);
      r_wr_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
      r_valid  <= '0;
    end else begin
      if (w_enq) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      if (w_deq) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
